// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding and address-field width helpers.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    WB_DRAIN,
    RF_REQ,
    RF_WAIT,
    RF_DRAIN,
    ALLOC
  } state_t;

  // Byte-offset bits below the word index; lines are one word wide.
  localparam int unsigned OFFSET_BITS = 2;

  function automatic int unsigned tag_bits(input int unsigned addr_width,
                                           input int unsigned index_bits);
    return addr_width - index_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid/dirty storage for the direct-mapped cache.
// Asynchronous read, synchronous full-entry write; valid/dirty cleared on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned TAG_BITS   = 25,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  input  logic                  wr_en,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_dirty
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;

  // Tag and data survive reset; only the status bits are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= wr_dirty;
    end
  end

  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Hits complete combinationally; misses stall the CPU and run the DRAM handshake.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS);

  state_t state, state_nx;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic                  unused_offset;

  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  hit;

  logic                  wr_en;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_dirty;

  assign idx           = cpu_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign cpu_tag       = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS];
  assign unused_offset = ^cpu_addr[OFFSET_BITS-1:0];

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .wr_en    (wr_en),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  assign hit       = line_valid & (line_tag == cpu_tag);
  assign cpu_rdata = line_data;
  assign cpu_stall = ~rst & cpu_req & (~hit | (state != IDLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    wr_tag    = cpu_tag;
    wr_data   = cpu_wdata;
    wr_dirty  = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_we) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
            end
          end else if (line_valid && line_dirty) begin
            state_nx = WB_REQ;
          end else if (cpu_we) begin
            state_nx = ALLOC;
          end else begin
            state_nx = RF_REQ;
          end
        end
      end

      WB_REQ: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx, {OFFSET_BITS{1'b0}}};
        mem_wdata = line_data;
        state_nx  = WB_WAIT;
      end

      // The victim entry is not written until ack, so address/data stay stable.
      WB_WAIT: begin
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx, {OFFSET_BITS{1'b0}}};
        mem_wdata = line_data;
        if (mem_ack) begin
          wr_en    = 1'b1;
          wr_tag   = line_tag;
          wr_data  = line_data;
          wr_dirty = 1'b0;
          state_nx = WB_DRAIN;
        end
      end

      WB_DRAIN: begin
        if (!mem_ack) begin
          state_nx = cpu_we ? ALLOC : RF_REQ;
        end
      end

      RF_REQ: begin
        mem_cs   = 1'b1;
        mem_addr = {cpu_tag, idx, {OFFSET_BITS{1'b0}}};
        state_nx = RF_WAIT;
      end

      RF_WAIT: begin
        mem_addr = {cpu_tag, idx, {OFFSET_BITS{1'b0}}};
        if (mem_ack) begin
          wr_en    = 1'b1;
          wr_data  = mem_rdata;
          wr_dirty = 1'b0;
          state_nx = RF_DRAIN;
        end
      end

      RF_DRAIN: begin
        if (!mem_ack) begin
          state_nx = IDLE;
        end
      end

      ALLOC: begin
        wr_en    = 1'b1;
        wr_dirty = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    if (rst) begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr_en     = 1'b0;
    end
  end

endmodule
